// File: rtl/axi_lite_core_regs.sv
// AXI4-Lite register front end for a sign/verify/hash core.
// Provides control, sticky status, operand windows (MSG/KEY) and a result window (OUT).
// AW and W are captured independently into hold registers; a write executes
// once both address and data are present, and the response follows one cycle later.
module axi_lite_core_regs #(
  parameter int MSG_WORDS  = 8,
  parameter int KEY_WORDS  = 8,
  parameter int OUT_WORDS  = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // write address / data / response channels
  input  logic [ADDR_WIDTH-1:0]   i_s_axi_awaddr,
  input  logic                    i_s_axi_awvalid,
  output logic                    o_s_axi_awready,
  input  logic [31:0]             i_s_axi_wdata,
  input  logic [3:0]              i_s_axi_wstrb,
  input  logic                    i_s_axi_wvalid,
  output logic                    o_s_axi_wready,
  output logic [1:0]              o_s_axi_bresp,
  output logic                    o_s_axi_bvalid,
  input  logic                    i_s_axi_bready,
  // read address / data channels
  input  logic [ADDR_WIDTH-1:0]   i_s_axi_araddr,
  input  logic                    i_s_axi_arvalid,
  output logic                    o_s_axi_arready,
  output logic [31:0]             o_s_axi_rdata,
  output logic [1:0]              o_s_axi_rresp,
  output logic                    o_s_axi_rvalid,
  input  logic                    i_s_axi_rready,
  // core interface
  output logic                    o_start_op,
  output logic [1:0]              o_op_select,
  output logic [MSG_WORDS*32-1:0] o_msg_in,
  output logic [KEY_WORDS*32-1:0] o_key_in,
  input  logic [OUT_WORDS*32-1:0] i_sig_out,
  input  logic [OUT_WORDS*32-1:0] i_hash_out,
  input  logic                    i_busy,
  input  logic                    i_done,
  input  logic                    i_error,
  output logic                    o_irq
);

  typedef enum logic [2:0] {
    RG_CTRL   = 3'd0,
    RG_STATUS = 3'd1,
    RG_INFO   = 3'd2,
    RG_MSG    = 3'd3,
    RG_KEY    = 3'd4,
    RG_OUT    = 3'd5,
    RG_NONE   = 3'd6
  } reg_sel_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] OP_HASH     = 2'd2;

  // Maps a byte address to a register class; misaligned, out-of-window and
  // anything above the 256-byte map fall into RG_NONE.
  function automatic reg_sel_e decode(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] hi;
    logic [3:0]            idx;
    reg_sel_e              sel;
    hi  = a >> 4'd8;
    idx = a[5:2];
    sel = RG_NONE;
    if ((hi == {ADDR_WIDTH{1'b0}}) && (a[1:0] == 2'b00)) begin
      case (a[7:6])
        2'b00: begin
          case (idx)
            4'h0:    sel = RG_CTRL;
            4'h1:    sel = RG_STATUS;
            4'h2:    sel = RG_INFO;
            default: sel = RG_NONE;
          endcase
        end
        2'b01:   sel = (int'(idx) < MSG_WORDS) ? RG_MSG : RG_NONE;
        2'b10:   sel = (int'(idx) < KEY_WORDS) ? RG_KEY : RG_NONE;
        2'b11:   sel = (int'(idx) < OUT_WORDS) ? RG_OUT : RG_NONE;
        default: sel = RG_NONE;
      endcase
    end else begin
      sel = RG_NONE;
    end
    return sel;
  endfunction

  // state
  logic                  r_aw_held, r_w_held;
  logic [ADDR_WIDTH-1:0] r_aw_addr;
  logic [31:0]           r_w_data;
  logic [3:0]            r_w_strb;
  logic                  r_bvalid, r_rvalid;
  logic [1:0]            r_bresp, r_rresp;
  logic [31:0]           r_rdata;
  logic                  r_irq_en, r_start_op, r_done_st, r_err_st, r_irq;
  logic [1:0]            r_op_select, r_last_op;
  logic [31:0]           r_msg [MSG_WORDS];
  logic [31:0]           r_key [KEY_WORDS];

  // combinational
  logic                  w_aw_hs, w_w_hs, w_ar_hs, w_wr_exec;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [31:0]           w_wr_data;
  logic [3:0]            w_wr_strb;
  logic [3:0]            w_wr_idx, w_rd_idx;
  reg_sel_e              w_wr_sel, w_rd_sel;
  logic                  w_wr_err, w_start_req, w_start_fire;
  logic                  w_ctrl_we, w_msg_we, w_key_we, w_done_clr, w_err_clr;
  logic [31:0]           w_rd_data;
  logic                  w_rd_err;

  // Readies are forced low while reset is asserted.
  assign o_s_axi_awready = rst_n & ~r_aw_held & ~r_bvalid;
  assign o_s_axi_wready  = rst_n & ~r_w_held & ~r_bvalid;
  assign o_s_axi_arready = rst_n & ~r_rvalid;

  assign w_aw_hs = i_s_axi_awvalid & o_s_axi_awready;
  assign w_w_hs  = i_s_axi_wvalid & o_s_axi_wready;
  assign w_ar_hs = i_s_axi_arvalid & o_s_axi_arready;

  // Held beats take priority; otherwise the beat handshaking this cycle is used.
  assign w_wr_addr = r_aw_held ? r_aw_addr : i_s_axi_awaddr;
  assign w_wr_data = r_w_held ? r_w_data : i_s_axi_wdata;
  assign w_wr_strb = r_w_held ? r_w_strb : i_s_axi_wstrb;
  assign w_wr_exec = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs) & ~r_bvalid;

  assign w_wr_sel = decode(w_wr_addr);
  assign w_rd_sel = decode(i_s_axi_araddr);
  assign w_wr_idx = w_wr_addr[5:2];
  assign w_rd_idx = i_s_axi_araddr[5:2];

  assign w_start_req  = w_wr_strb[0] & w_wr_data[0];
  assign w_ctrl_we    = w_wr_exec & (w_wr_sel == RG_CTRL) & w_wr_strb[0];
  assign w_start_fire = w_wr_exec & (w_wr_sel == RG_CTRL) & w_start_req & ~i_busy;
  assign w_msg_we     = w_wr_exec & (w_wr_sel == RG_MSG) & ~i_busy;
  assign w_key_we     = w_wr_exec & (w_wr_sel == RG_KEY) & ~i_busy;
  assign w_done_clr   = w_wr_exec & (w_wr_sel == RG_STATUS) & w_wr_strb[0] & w_wr_data[1];
  assign w_err_clr    = w_wr_exec & (w_wr_sel == RG_STATUS) & w_wr_strb[0] & w_wr_data[2];

  // Write response code for the executing write.
  always_comb begin
    w_wr_err = 1'b1;
    case (w_wr_sel)
      RG_CTRL:        w_wr_err = w_start_req & i_busy;
      RG_STATUS:      w_wr_err = 1'b0;
      RG_MSG, RG_KEY: w_wr_err = i_busy;
      default:        w_wr_err = 1'b1;
    endcase
  end

  // Read data mux; reflects register contents before any same-cycle write.
  always_comb begin
    w_rd_data = 32'h0000_0000;
    w_rd_err  = 1'b0;
    case (w_rd_sel)
      RG_CTRL:   w_rd_data = {28'h000_0000, r_irq_en, r_op_select, 1'b0};
      RG_STATUS: w_rd_data = {29'h0000_0000, r_err_st, r_done_st, i_busy};
      RG_INFO:   w_rd_data = {8'(OUT_WORDS), 8'(KEY_WORDS), 8'(MSG_WORDS), 8'h01};
      RG_MSG: begin
        for (int i = 0; i < MSG_WORDS; i++) begin
          if (w_rd_idx == 4'(i)) w_rd_data = r_msg[i];
          else                   w_rd_data = w_rd_data;
        end
      end
      RG_KEY: begin
        for (int i = 0; i < KEY_WORDS; i++) begin
          if (w_rd_idx == 4'(i)) w_rd_data = r_key[i];
          else                   w_rd_data = w_rd_data;
        end
      end
      RG_OUT: begin
        for (int i = 0; i < OUT_WORDS; i++) begin
          if (w_rd_idx == 4'(i))
            w_rd_data = (r_last_op == OP_HASH) ? i_hash_out[32*i +: 32] : i_sig_out[32*i +: 32];
          else
            w_rd_data = w_rd_data;
        end
      end
      default: w_rd_err = 1'b1;
    endcase
  end

  // AW/W hold registers: capture on handshake, clear when the write executes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aw_held <= 1'b0;
      r_aw_addr <= {ADDR_WIDTH{1'b0}};
      r_w_held  <= 1'b0;
      r_w_data  <= 32'h0000_0000;
      r_w_strb  <= 4'h0;
    end else begin
      if (w_wr_exec) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end else begin
        if (w_aw_hs) begin
          r_aw_held <= 1'b1;
          r_aw_addr <= i_s_axi_awaddr;
        end
        if (w_w_hs) begin
          r_w_held <= 1'b1;
          r_w_data <= i_s_axi_wdata;
          r_w_strb <= i_s_axi_wstrb;
        end
      end
    end
  end

  // Write response channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else if (w_wr_exec) begin
      r_bvalid <= 1'b1;
      r_bresp  <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
    end else if (r_bvalid && i_s_axi_bready) begin
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end
  end

  // Read data channel; data held stable until the master accepts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_rresp  <= RESP_OKAY;
      r_rdata  <= 32'h0000_0000;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rresp  <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
      r_rdata  <= w_rd_err ? 32'h0000_0000 : w_rd_data;
    end else if (r_rvalid && i_s_axi_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  // CTRL fields, start pulse and the op latched at the last accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_en    <= 1'b0;
      r_op_select <= 2'd0;
      r_last_op   <= 2'd0;
      r_start_op  <= 1'b0;
    end else begin
      r_start_op <= w_start_fire;
      if (w_ctrl_we) begin
        r_irq_en    <= w_wr_data[3];
        r_op_select <= w_wr_data[2:1];
      end
      if (w_start_fire) r_last_op <= w_wr_data[2:1];
    end
  end

  // Sticky status bits: a set from the core wins over a software clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done_st <= 1'b0;
      r_err_st  <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      if (i_done)          r_done_st <= 1'b1;
      else if (w_done_clr) r_done_st <= 1'b0;
      if (i_error)         r_err_st  <= 1'b1;
      else if (w_err_clr)  r_err_st  <= 1'b0;
      r_irq <= r_irq_en & (r_done_st | r_err_st);
    end
  end

  // Message window with byte-lane writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MSG_WORDS; i++) r_msg[i] <= 32'h0000_0000;
    end else begin
      for (int i = 0; i < MSG_WORDS; i++) begin
        for (int k = 0; k < 4; k++) begin
          if (w_msg_we && (w_wr_idx == 4'(i)) && w_wr_strb[k])
            r_msg[i][8*k +: 8] <= w_wr_data[8*k +: 8];
        end
      end
    end
  end

  // Key window with byte-lane writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < KEY_WORDS; i++) r_key[i] <= 32'h0000_0000;
    end else begin
      for (int i = 0; i < KEY_WORDS; i++) begin
        for (int k = 0; k < 4; k++) begin
          if (w_key_we && (w_wr_idx == 4'(i)) && w_wr_strb[k])
            r_key[i][8*k +: 8] <= w_wr_data[8*k +: 8];
        end
      end
    end
  end

  for (genvar g = 0; g < MSG_WORDS; g++) begin : g_msg
    assign o_msg_in[32*g +: 32] = r_msg[g];
  end
  for (genvar g = 0; g < KEY_WORDS; g++) begin : g_key
    assign o_key_in[32*g +: 32] = r_key[g];
  end

  assign o_s_axi_bvalid = r_bvalid;
  assign o_s_axi_bresp  = r_bresp;
  assign o_s_axi_rvalid = r_rvalid;
  assign o_s_axi_rresp  = r_rresp;
  assign o_s_axi_rdata  = r_rdata;
  assign o_start_op     = r_start_op;
  assign o_op_select    = r_op_select;
  assign o_irq          = r_irq;

endmodule

// File: tb/tb_axi_lite_core_regs.sv
// Directed testbench for axi_lite_core_regs with hand-computed expectations.
module tb_axi_lite_core_regs;
  localparam int MW = 8;
  localparam int KW = 8;
  localparam int OW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]       awaddr, araddr;
  logic             awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0]      wdata, rdata;
  logic [3:0]       wstrb;
  logic [1:0]       bresp, rresp, op_select;
  logic             arvalid, arready, rvalid, rready;
  logic             start_op, busy, done, error, irq;
  logic [MW*32-1:0] msg_in;
  logic [KW*32-1:0] key_in;
  logic [OW*32-1:0] sig_out, hash_out;

  int n_run = 0;
  int n_fail = 0;
  int so_cnt = 0;

  axi_lite_core_regs #(.MSG_WORDS(MW), .KEY_WORDS(KW), .OUT_WORDS(OW), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_s_axi_awaddr(awaddr), .i_s_axi_awvalid(awvalid), .o_s_axi_awready(awready),
    .i_s_axi_wdata(wdata), .i_s_axi_wstrb(wstrb), .i_s_axi_wvalid(wvalid), .o_s_axi_wready(wready),
    .o_s_axi_bresp(bresp), .o_s_axi_bvalid(bvalid), .i_s_axi_bready(bready),
    .i_s_axi_araddr(araddr), .i_s_axi_arvalid(arvalid), .o_s_axi_arready(arready),
    .o_s_axi_rdata(rdata), .o_s_axi_rresp(rresp), .o_s_axi_rvalid(rvalid), .i_s_axi_rready(rready),
    .o_start_op(start_op), .o_op_select(op_select), .o_msg_in(msg_in), .o_key_in(key_in),
    .i_sig_out(sig_out), .i_hash_out(hash_out), .i_busy(busy), .i_done(done), .i_error(error),
    .o_irq(irq)
  );

  // counts start pulses seen by the core
  always @(posedge clk) if (start_op) so_cnt <= so_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int lat, output logic sob);
    int n;
    logic aw_hs, w_hs;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      aw_hs = awvalid & awready;
      w_hs  = wvalid & wready;
      tick(); n++;
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid  = 1'b0;
    end
    chk("wr_accept", {30'h0, awvalid, wvalid}, 32'h0);
    awvalid = 1'b0; wvalid = 1'b0; n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    chk("wr_bvalid", {31'h0, bvalid}, 32'h1);
    lat = n; resp = bresp; sob = start_op;
    bready = 1'b1; tick(); bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    araddr = a; arvalid = 1'b1; n = 0;
    while (!arready && n < 20) begin tick(); n++; end
    tick(); arvalid = 1'b0; n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    chk("rd_rvalid", {31'h0, rvalid}, 32'h1);
    d = rdata; resp = rresp;
    rready = 1'b1; tick(); rready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] d;
    logic        sob;
    int          lat, c0;
    awaddr = 8'h00; awvalid = 1'b0; wdata = 32'h0; wstrb = 4'h0; wvalid = 1'b0; bready = 1'b0;
    araddr = 8'h00; arvalid = 1'b0; rready = 1'b0; busy = 1'b0; done = 1'b0; error = 1'b0;
    for (int i = 0; i < OW; i++) begin
      sig_out[32*i +: 32]  = 32'h5100_0000 | 32'(i);
      hash_out[32*i +: 32] = 32'hA500_0000 | 32'(i);
    end
    repeat (3) tick();

    // reset state
    chk("rst_awready", {31'h0, awready}, 32'h0);
    chk("rst_wready", {31'h0, wready}, 32'h0);
    chk("rst_arready", {31'h0, arready}, 32'h0);
    chk("rst_bvalid", {31'h0, bvalid}, 32'h0);
    chk("rst_rvalid", {31'h0, rvalid}, 32'h0);
    chk("rst_start_op", {31'h0, start_op}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_msg0", msg_in[31:0], 32'h0);
    rst_n = 1'b1;
    tick();
    chk("rel_awready", {31'h0, awready}, 32'h1);
    chk("rel_wready", {31'h0, wready}, 32'h1);
    chk("rel_arready", {31'h0, arready}, 32'h1);

    // W at N, AW at N+3 -> bvalid at N+4
    wdata = 32'hA5A5_5A5A; wstrb = 4'hF; wvalid = 1'b1;
    tick(); wvalid = 1'b0;
    chk("w_held_wready", {31'h0, wready}, 32'h0);
    chk("w_held_awready", {31'h0, awready}, 32'h1);
    tick(); tick();
    awaddr = 8'h40; awvalid = 1'b1;
    chk("split_no_b_yet", {31'h0, bvalid}, 32'h0);
    tick(); awvalid = 1'b0;
    chk("split_bvalid", {31'h0, bvalid}, 32'h1);
    chk("split_bresp", {30'h0, bresp}, 32'h0);
    chk("split_msg0", msg_in[31:0], 32'hA5A5_5A5A);
    bready = 1'b1; tick(); bready = 1'b0;
    chk("split_b_done", {31'h0, bvalid}, 32'h0);

    // same-cycle AW/W latency
    axi_write(8'h44, 32'h1111_1111, 4'hF, resp, lat, sob);
    chk("wr_lat", 32'(lat), 32'h0);
    chk("wr_msg1_resp", {30'h0, resp}, 32'h0);

    // start with op hash
    c0 = so_cnt;
    axi_write(8'h00, 32'h0000_0005, 4'hF, resp, lat, sob);
    chk("start_resp", {30'h0, resp}, 32'h0);
    chk("start_at_b", {31'h0, sob}, 32'h1);
    repeat (3) tick();
    chk("start_count", 32'(so_cnt - c0), 32'h1);
    chk("op_select", {30'h0, op_select}, 32'h2);
    axi_read(8'h00, d, resp);
    chk("ctrl_rb", d, 32'h0000_0004);

    // key byte strobe
    axi_write(8'h80, 32'h1122_3344, 4'hF, resp, lat, sob);
    axi_write(8'h80, 32'h0000_BB00, 4'h2, resp, lat, sob);
    chk("key_strb", key_in[31:0], 32'h1122_BB44);
    axi_read(8'h80, d, resp);
    chk("key_rb", d, 32'h1122_BB44);

    // OUT window follows last started op (hash)
    axi_read(8'hC4, d, resp);
    chk("out_hash", d, 32'hA500_0001);
    chk("out_hash_resp", {30'h0, resp}, 32'h0);
    axi_write(8'hC0, 32'hFFFF_FFFF, 4'hF, resp, lat, sob);
    chk("out_wr_resp", {30'h0, resp}, 32'h2);

    // busy: start rejected, fields updated; operand writes rejected
    busy = 1'b1;
    c0 = so_cnt;
    axi_write(8'h00, 32'h0000_0003, 4'hF, resp, lat, sob);
    chk("busy_start_resp", {30'h0, resp}, 32'h2);
    chk("busy_no_start", {31'h0, sob}, 32'h0);
    axi_read(8'h00, d, resp);
    chk("busy_ctrl_rb", d, 32'h0000_0002);
    axi_write(8'h40, 32'hDEAD_BEEF, 4'hF, resp, lat, sob);
    chk("busy_msg_resp", {30'h0, resp}, 32'h2);
    chk("busy_msg_kept", msg_in[31:0], 32'hA5A5_5A5A);
    axi_read(8'h04, d, resp);
    chk("status_busy", d, 32'h0000_0001);
    chk("busy_start_cnt", 32'(so_cnt - c0), 32'h0);
    busy = 1'b0;
    axi_read(8'hC4, d, resp);
    chk("out_still_hash", d, 32'hA500_0001);
    axi_write(8'h00, 32'h0000_0001, 4'hF, resp, lat, sob);
    chk("start_sign", {31'h0, sob}, 32'h1);
    axi_read(8'hC4, d, resp);
    chk("out_sig", d, 32'h5100_0001);

    // error decoding
    axi_read(8'h03, d, resp);
    chk("mis_resp", {30'h0, resp}, 32'h2);
    chk("mis_data", d, 32'h0);
    axi_read(8'h30, d, resp);
    chk("unmap_resp", {30'h0, resp}, 32'h2);
    chk("unmap_data", d, 32'h0);
    axi_read(8'h60, d, resp);
    chk("beyond_msg_resp", {30'h0, resp}, 32'h2);
    axi_write(8'h08, 32'hFFFF_FFFF, 4'hF, resp, lat, sob);
    chk("info_wr_resp", {30'h0, resp}, 32'h2);
    axi_read(8'h08, d, resp);
    chk("info_rb", d, 32'h1008_0801);
    chk("info_resp", {30'h0, resp}, 32'h0);

    // concurrent read and write of MSG[1]: read returns the old value
    araddr = 8'h44; arvalid = 1'b1;
    awaddr = 8'h44; awvalid = 1'b1; wdata = 32'h2222_2222; wstrb = 4'hF; wvalid = 1'b1;
    tick(); arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    chk("conc_rvalid", {31'h0, rvalid}, 32'h1);
    chk("conc_old", rdata, 32'h1111_1111);
    chk("conc_bvalid", {31'h0, bvalid}, 32'h1);
    bready = 1'b1; rready = 1'b1; tick(); bready = 1'b0; rready = 1'b0;
    axi_read(8'h44, d, resp);
    chk("conc_new", d, 32'h2222_2222);

    // sticky done with simultaneous W1C; set wins; irq one cycle later
    axi_write(8'h00, 32'h0000_0008, 4'hF, resp, lat, sob);
    awaddr = 8'h04; awvalid = 1'b1; wdata = 32'h0000_0002; wstrb = 4'hF; wvalid = 1'b1; done = 1'b1;
    tick(); awvalid = 1'b0; wvalid = 1'b0; done = 1'b0;
    chk("w1c_race_b", {31'h0, bvalid}, 32'h1);
    chk("irq_delay", {31'h0, irq}, 32'h0);
    bready = 1'b1; tick(); bready = 1'b0;
    chk("irq_set", {31'h0, irq}, 32'h1);
    axi_read(8'h04, d, resp);
    chk("done_sticky", d, 32'h0000_0002);
    axi_write(8'h04, 32'h0000_0002, 4'hF, resp, lat, sob);
    chk("w1c_resp", {30'h0, resp}, 32'h0);
    chk("irq_clear", {31'h0, irq}, 32'h0);
    axi_read(8'h04, d, resp);
    chk("done_cleared", d, 32'h0);
    error = 1'b1; tick(); error = 1'b0;
    axi_read(8'h04, d, resp);
    chk("err_sticky", d, 32'h0000_0004);
    chk("irq_err", {31'h0, irq}, 32'h1);
    axi_write(8'h04, 32'h0000_0004, 4'hF, resp, lat, sob);
    axi_read(8'h04, d, resp);
    chk("err_cleared", d, 32'h0);
    axi_write(8'h00, 32'h0000_0000, 4'hF, resp, lat, sob);
    done = 1'b1; tick(); done = 1'b0;
    tick(); tick();
    chk("irq_masked", {31'h0, irq}, 32'h0);
    axi_write(8'h04, 32'h0000_0002, 4'hF, resp, lat, sob);

    // read held while rready low
    araddr = 8'h08; arvalid = 1'b1;
    tick(); arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("hold_rvalid", {31'h0, rvalid}, 32'h1);
      chk("hold_rdata", rdata, 32'h1008_0801);
      chk("hold_arready", {31'h0, arready}, 32'h0);
      tick();
    end
    rready = 1'b1; tick(); rready = 1'b0;
    chk("hold_done_rvalid", {31'h0, rvalid}, 32'h0);
    chk("hold_done_arready", {31'h0, arready}, 32'h1);

    // reset in the middle of a write: no response afterwards
    awaddr = 8'h48; awvalid = 1'b1;
    tick(); awvalid = 1'b0;
    chk("mid_aw_held", {31'h0, awready}, 32'h0);
    rst_n = 1'b0; #1;
    chk("mid_rst_awready", {31'h0, awready}, 32'h0);
    tick(); rst_n = 1'b1;
    tick();
    chk("mid_rel_awready", {31'h0, awready}, 32'h1);
    repeat (3) tick();
    chk("mid_no_b", {31'h0, bvalid}, 32'h0);
    chk("mid_msg_cleared", msg_in[31:0], 32'h0);
    chk("mid_key_cleared", key_in[31:0], 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_lite_core_regs.md
AXI_LITE_CORE_REGS -- requirements
Module: axi_lite_core_regs

Interface
REQ-001 Parameter: MSG_WORDS, 8, 32-bit words in message window (1..16).
REQ-002 Parameter: KEY_WORDS, 8, 32-bit words in key window (1..16).
REQ-003 Parameter: OUT_WORDS, 16, 32-bit words in result window (1..16).
REQ-004 Parameter: ADDR_WIDTH, 8, byte address width (fixed map fits 256 B); DATA_WIDTH fixed 32.
REQ-005 clk  in  1  single clock; all logic posedge clk.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 s_axi_aw{addr,valid}/awready, s_axi_w{data,strb,valid}/wready, s_axi_b{resp,valid}/bready  AXI4-Lite write channels; addr ADDR_WIDTH, data 32, strb 4, resp 2.
REQ-008 s_axi_ar{addr,valid}/arready, s_axi_r{data,resp,valid}/rready  AXI4-Lite read channels.
REQ-009 start_op  out  1  one-cycle start pulse to core.
REQ-010 op_select  out  2  0 sign, 1 verify, 2 hash, 3 reserved.
REQ-011 msg_in  out  MSG_WORDS*32; key_in  out  KEY_WORDS*32  operands; word 0 = bits [31:0].
REQ-012 sig_out  in  OUT_WORDS*32; hash_out  in  OUT_WORDS*32  core results.
REQ-013 busy, done, error  in  1 each  core status.
REQ-014 irq  out  1  level interrupt.

Function
REQ-015 Map (byte offsets): 0x00 CTRL RW {bit3 irq_en, bits2:1 op_select, bit0 start}; 0x04 STATUS {bit0 busy RO, bit1 done_st W1C, bit2 err_st W1C}; 0x08 INFO RO {OUT_WORDS[7:0], KEY_WORDS[7:0], MSG_WORDS[7:0], 8'h01}; 0x40+4i MSG[i] RW; 0x80+4i KEY[i] RW; 0xC0+4i OUT[i] RO.
REQ-016 OUT[i] reads hash_out word i when last started op_select==2, else sig_out word i.
REQ-017 Unmapped, beyond-window, or addr[1:0]!=0 access: resp SLVERR (2'b10), read data 0, no state change.
REQ-018 Write to RO register (INFO, OUT): SLVERR, no effect; STATUS write is legal (W1C only).
REQ-019 AW and W accepted independently: awready = !aw_held && !bvalid; wready = !w_held && !bvalid; each captured into a hold register.
REQ-020 Write executes in the cycle both address and data are held or handshaking; bvalid asserts next cycle, held until bready; hold registers clear on execution.
REQ-021 Latency: AW and W handshaking in same cycle N -> register updated and bvalid at N+1.
REQ-022 Byte strobes: on RW registers only lanes with wstrb[k]=1 update; CTRL start bit honoured only if wstrb[0]=1.
REQ-023 CTRL write with start=1 and busy=0: start_op=1 for exactly the cycle after execution; stored start bit reads back 0.
REQ-024 CTRL write with start=1 while busy=1: op_select/irq_en updated, no start_op, bresp SLVERR.
REQ-025 MSG/KEY writes while busy=1: ignored, SLVERR.
REQ-026 arready = !rvalid; AR handshake at N -> registered rdata/rresp, rvalid at N+1, held stable until rready.
REQ-027 Read and write may proceed concurrently; read of register written in same cycle returns old value.
REQ-028 done_st sets on any cycle done=1, err_st on error=1; W1C clears bit; simultaneous set and clear: set wins.
REQ-029 irq = irq_en && (done_st || err_st), registered (1-cycle delay).
REQ-030 bresp/rresp OKAY (2'b00) in all cases not listed as SLVERR.

Reset
REQ-031 While rst_n=0: all readies, bvalid, rvalid, start_op, irq = 0; resp = 0; rdata = 0; CTRL, MSG, KEY, sticky bits, hold registers, last-op = 0.
REQ-032 Reset asserted mid-transaction aborts it; no response issued after release.
REQ-033 First cycle after release: awready, wready, arready = 1.

Verification
REQ-034 W at N, AW 0x40 at N+3, wdata 0xA5A5_5A5A strb 0xF -> bvalid N+4 OKAY, msg_in[31:0]=0xA5A5_5A5A.
REQ-035 Write CTRL 0x5 (busy=0) -> start_op high exactly one cycle, op_select=2; CTRL readback 0x4.
REQ-036 Write KEY[0] strb 0x2 data 0x0000_BB00 over 0x1122_3344 -> key_in[31:0]=0x1122_BB44.
REQ-037 Read 0x03, 0x30, write 0x08 -> SLVERR each, read data 0, INFO unchanged.
REQ-038 irq_en=1, pulse done; write STATUS 0x2 in same cycle as done=1 -> done_st stays 1; later write 0x2 -> done_st 0, irq 0 next cycle.
REQ-039 Read with rready low 5 cycles -> rvalid and rdata stable, arready 0 until handshake.
